// File: rtl/fetch_pkt_queue_if.sv
// fetch_pkt_queue_if: request/response/decode handshake bundle for fetch_pkt_queue
interface fetch_pkt_queue_if #(parameter int FETCH_W = 2, DEPTH = 4, EPOCH_W = 2);
  logic flush, req_valid, req_fire, hold_req, hold_ack;
  logic [EPOCH_W-1:0] req_epoch, rsp_epoch;
  logic rsp_valid, rsp_taken, rsp_excp_flag;
  logic [31:0] rsp_pc, rsp_pc_next, rsp_badv;
  logic [32*FETCH_W-1:0] rsp_inst, out_inst;
  logic [6:0] rsp_excp, out_excp;
  logic out_valid, out_ready, out_taken, out_excp_flag;
  logic [31:0] out_pc, out_pc_next, out_badv;
  logic [FETCH_W-1:0] out_mask;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output flush, req_fire, hold_req, rsp_valid, rsp_epoch, rsp_pc, rsp_pc_next, rsp_taken,
           rsp_inst, rsp_excp, rsp_excp_flag, rsp_badv, out_ready,
    input  req_valid, req_epoch, hold_ack, out_valid, out_pc, out_pc_next, out_taken,
           out_inst, out_mask, out_excp, out_excp_flag, out_badv, count
  );
  modport slave (
    input  flush, req_fire, hold_req, rsp_valid, rsp_epoch, rsp_pc, rsp_pc_next, rsp_taken,
           rsp_inst, rsp_excp, rsp_excp_flag, rsp_badv, out_ready,
    output req_valid, req_epoch, hold_ack, out_valid, out_pc, out_pc_next, out_taken,
           out_inst, out_mask, out_excp, out_excp_flag, out_badv, count
  );
endinterface

// File: rtl/fetch_pkt_queue.sv
// fetch_pkt_queue: credit-gated, epoch-tagged fetch packet ring buffer with lane compaction and drain/hold
// Define FPQ_BYPASS_EN to present a matching response combinationally when the queue is empty.
module fetch_pkt_queue #(
  parameter int FETCH_W = 2,
  parameter int DEPTH = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int EPOCH_W = 2
) (
  input logic clk,
  input logic rst,
  fetch_pkt_queue_if.slave bus
);
  localparam logic [31:0] NOP = 32'h0340_0000;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int OW = FETCH_W > 1 ? $clog2(FETCH_W) : 1;
  typedef struct packed {
    logic [31:0] pc, pc_next;
    logic taken;
    logic [32*FETCH_W-1:0] inst;
    logic [FETCH_W-1:0] mask;
    logic [6:0] excp;
    logic excp_flag;
    logic [31:0] badv;
  } pkt_t;
  typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;
  pkt_t mem [DEPTH];
  pkt_t rsp_pkt, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] inflight, inflight_nxt;
  logic [EPOCH_W-1:0] epoch;
  logic [OW-1:0] off;
  logic match, bypass, pop, wr;
  state_t state, state_nxt;
  // lane 0 of the stored packet is the instruction at the fetch PC
  always_comb begin
    rsp_pkt = '0;
    off = FETCH_W > 1 ? bus.rsp_pc[2 +: OW] : '0;
    rsp_pkt.pc = bus.rsp_pc;
    rsp_pkt.pc_next = bus.rsp_pc_next;
    rsp_pkt.taken = bus.rsp_taken;
    rsp_pkt.excp = bus.rsp_excp;
    rsp_pkt.excp_flag = bus.rsp_excp_flag;
    rsp_pkt.badv = bus.rsp_badv;
    for (int i = 0; i < FETCH_W; i++) begin
      rsp_pkt.inst[32*i +: 32] = i + int'(off) < FETCH_W ? bus.rsp_inst[32*((i + int'(off)) % FETCH_W) +: 32] : NOP;
      rsp_pkt.mask[i] = bus.rsp_excp_flag ? i == 0 : i + int'(off) < FETCH_W;
    end
  end
  always_comb begin
    match = !rst && bus.rsp_valid && bus.rsp_epoch == epoch && !bus.flush;
`ifdef FPQ_BYPASS_EN
    bypass = match && count == '0 && bus.out_ready;
`else
    bypass = 1'b0;
`endif
    pop = count != '0 && bus.out_ready;
    wr = match && !bypass && (count != CW'(DEPTH) || pop);
    inflight_nxt = inflight + IW'(bus.req_fire) - IW'(bus.rsp_valid && inflight != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      inflight <= '0;
      epoch <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        epoch <= epoch + 1'b1;
      end else begin
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(wr) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= rsp_pkt;
  always_ff @(posedge clk) state <= rst ? RUN : state_nxt;
  always_comb begin
    state_nxt = state == RUN ? (bus.hold_req ? DRAIN : RUN)
              : state == DRAIN ? (!bus.hold_req ? RUN : inflight_nxt == '0 ? HOLD : DRAIN)
              : (bus.hold_req ? HOLD : RUN);
  end
  always_comb begin
    bus.req_valid = !rst && state == RUN && !bus.flush
                    && 32'(count) + 32'(inflight) < DEPTH && 32'(inflight) < MAX_INFLIGHT;
    bus.hold_ack = state == HOLD;
    bus.req_epoch = epoch;
    bus.count = count;
    head = bypass ? rsp_pkt : mem[rd_ptr];
    bus.out_valid = count != '0 || bypass;
    bus.out_pc = bus.out_valid ? head.pc : '0;
    bus.out_pc_next = bus.out_valid ? head.pc_next : '0;
    bus.out_taken = bus.out_valid && head.taken;
    bus.out_inst = bus.out_valid ? head.inst : {FETCH_W{NOP}};
    bus.out_mask = bus.out_valid ? head.mask : '0;
    bus.out_excp = bus.out_valid ? head.excp : '0;
    bus.out_excp_flag = bus.out_valid && head.excp_flag;
    bus.out_badv = bus.out_valid ? head.badv : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_rsp_idle: assert (!(bus.rsp_valid && inflight == '0));
      a_push_full: assert (!(match && !bypass && count == CW'(DEPTH) && !pop));
    end
  end
endmodule

// File: tb/tb_fetch_pkt_queue.sv
// tb_fetch_pkt_queue: queue-level reference model plus directed scenarios for fetch_pkt_queue
module tb_fetch_pkt_queue;
  localparam logic [31:0] NOP = 32'h0340_0000;
`ifdef FPQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [31:0] pc, pc_next;
    logic taken;
    logic [63:0] inst;
    logic [1:0] mask;
    logic [6:0] excp;
    logic flag;
    logic [31:0] badv;
  } pkt_t;
  logic clk = 1'b0, rst = 1'b1, chk_en = 1'b0;
  int n_pass = 0, n_chk = 0;
  pkt_t q[$];
  int m_inf = 0, m_ep = 0, m_mode = 0;
  fetch_pkt_queue_if #(.FETCH_W(2), .DEPTH(4), .EPOCH_W(2)) b();
  fetch_pkt_queue_if #(.FETCH_W(4), .DEPTH(4), .EPOCH_W(2)) b4();
  fetch_pkt_queue #(.FETCH_W(2), .DEPTH(4), .MAX_INFLIGHT(4), .EPOCH_W(2)) dut (.clk(clk), .rst(rst), .bus(b));
  fetch_pkt_queue #(.FETCH_W(4), .DEPTH(4), .MAX_INFLIGHT(4), .EPOCH_W(2)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s got %0h want %0h", n, a, e);
  endtask
  function automatic pkt_t mk();
    pkt_t p;
    p.pc = b.rsp_pc;
    p.pc_next = b.rsp_pc_next;
    p.taken = b.rsp_taken;
    p.inst = b.rsp_pc[2] ? {NOP, b.rsp_inst[63:32]} : b.rsp_inst;
    p.mask = (b.rsp_excp_flag || b.rsp_pc[2]) ? 2'b01 : 2'b11;
    p.excp = b.rsp_excp;
    p.flag = b.rsp_excp_flag;
    p.badv = b.rsp_badv;
    return p;
  endfunction
  function automatic bit m_match();
    return !rst && b.rsp_valid && int'(b.rsp_epoch) == m_ep && !b.flush;
  endfunction
  always @(posedge clk) begin
    int nin;
    bit byp;
    byp = BYP && m_match() && q.size() == 0 && b.out_ready;
    nin = m_inf + int'(b.req_fire) - ((b.rsp_valid && m_inf > 0) ? 1 : 0);
    if (rst) begin
      q.delete();
      m_inf = 0;
      m_ep = 0;
      m_mode = 0;
    end else begin
      if (b.flush) begin
        q.delete();
        m_ep = (m_ep + 1) % 4;
      end else begin
        if (q.size() > 0 && b.out_ready) void'(q.pop_front());
        if (m_match() && !byp && q.size() < 4) q.push_back(mk());
      end
      m_mode = m_mode == 0 ? (b.hold_req ? 1 : 0) : m_mode == 1 ? (!b.hold_req ? 0 : nin == 0 ? 2 : 1) : (b.hold_req ? 2 : 0);
      m_inf = nin;
    end
  end
  always @(negedge clk) begin
    pkt_t e;
    bit byp;
    if (chk_en) begin
      byp = BYP && m_match() && q.size() == 0 && b.out_ready;
      e = '{pc: 0, pc_next: 0, taken: 0, inst: {NOP, NOP}, mask: 0, excp: 0, flag: 0, badv: 0};
      if (byp) e = mk();
      else if (q.size() > 0) e = q[0];
      chk("req_valid", b.req_valid, !rst && m_mode == 0 && !b.flush && q.size() + m_inf < 4 && m_inf < 4);
      chk("req_epoch", b.req_epoch, m_ep);
      chk("hold_ack", b.hold_ack, m_mode == 2);
      chk("out_valid", b.out_valid, q.size() > 0 || byp);
      chk("count", b.count, q.size());
      chk("out_pc", b.out_pc, e.pc);
      chk("out_pc_next", b.out_pc_next, e.pc_next);
      chk("out_taken", b.out_taken, e.taken);
      chk("out_inst", b.out_inst, e.inst);
      chk("out_mask", b.out_mask, e.mask);
      chk("out_excp", {b.out_excp_flag, b.out_excp}, {e.flag, e.excp});
      chk("out_badv", b.out_badv, e.badv);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #2;
    b.req_fire = 0; b.rsp_valid = 0; b.flush = 0;
    b4.req_fire = 0; b4.rsp_valid = 0;
  endtask
  task automatic fire(input int n);
    for (int i = 0; i < n; i++) begin
      b.req_fire = 1;
      cyc();
    end
  endtask
  task automatic set_rsp(input logic [31:0] pc, input logic [63:0] inst, input logic [1:0] ep);
    b.rsp_pc = pc; b.rsp_pc_next = pc + 8; b.rsp_taken = pc[5];
    b.rsp_inst = inst; b.rsp_epoch = ep; b.rsp_valid = 1;
  endtask
  task automatic rsp(input logic [31:0] pc, input logic [63:0] inst, input logic [1:0] ep);
    set_rsp(pc, inst, ep);
    cyc();
  endtask
  initial begin
    b.flush = 0; b.req_fire = 0; b.rsp_valid = 0; b.rsp_epoch = 0; b.rsp_pc = 0; b.rsp_pc_next = 0;
    b.rsp_taken = 0; b.rsp_inst = 0; b.rsp_excp = 0; b.rsp_excp_flag = 0; b.rsp_badv = 0;
    b.hold_req = 0; b.out_ready = 0;
    b4.flush = 0; b4.req_fire = 0; b4.rsp_valid = 0; b4.rsp_epoch = 0; b4.rsp_pc = 0; b4.rsp_pc_next = 0;
    b4.rsp_taken = 0; b4.rsp_inst = 0; b4.rsp_excp = 0; b4.rsp_excp_flag = 0; b4.rsp_badv = 0;
    b4.hold_req = 0; b4.out_ready = 0;
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_req_valid", b.req_valid, 0);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_out_inst", b.out_inst, 64'h0340_0000_0340_0000);
    chk("rst_out_mask", b.out_mask, 0);
    rst = 0;
    cyc();
    chk("run_req_valid", b.req_valid, 1);
    // 4-lane instance: offset 3 leaves only lane 0 valid
    b4.req_fire = 1;
    cyc();
    b4.rsp_pc = 32'h1c00_000c; b4.rsp_inst = {32'hdddd0004, 32'hcccc0004, 32'hbbbb0004, 32'haaaa0004};
    b4.rsp_valid = 1;
    cyc();
    chk("w4_mask", b4.out_mask, 4'b0001);
    chk("w4_inst", b4.out_inst, {NOP, NOP, NOP, 32'hdddd0004});
    // credit exhausted by four outstanding fetches
    fire(4);
    chk("t1_credit", b.req_valid, 0);
    rsp(32'h1c00_0000, {32'hbbbb0001, 32'haaaa0001}, 0);
    chk("t1_valid", b.out_valid, 1);
    chk("t1_mask", b.out_mask, 2'b11);
    chk("t1_inst", b.out_inst, {32'hbbbb0001, 32'haaaa0001});
    rsp(32'h1c00_0004, {32'hbbbb0002, 32'haaaa0002}, 0);
    b.out_ready = 1;
    cyc();
    b.out_ready = 0;
    chk("t2_inst", b.out_inst, {NOP, 32'hbbbb0002});
    chk("t2_mask", b.out_mask, 2'b01);
    b.rsp_excp_flag = 1; b.rsp_excp = 7'h0c; b.rsp_badv = 32'h1c00_0040;
    rsp(32'h1c00_0040, {32'hbbbb0003, 32'haaaa0003}, 0);
    b.rsp_excp_flag = 0; b.rsp_excp = 0; b.rsp_badv = 0;
    b.out_ready = 1;
    cyc();
    b.out_ready = 0;
    chk("t2_excp_mask", b.out_mask, 2'b01);
    chk("t2_excp", {b.out_excp_flag, b.out_excp}, 8'h8c);
    rsp(32'h1c00_0010, {32'hbbbb0005, 32'haaaa0005}, 0);
    b.out_ready = 1;
    repeat (2) cyc();
    b.out_ready = 0;
    chk("t2_drained", b.count, 0);
    // stale responses after a flush
    fire(2);
    b.flush = 1;
    cyc();
    chk("t3_epoch", b.req_epoch, 1);
    rsp(32'h1c00_0080, 64'h1111, 0);
    rsp(32'h1c00_0088, 64'h2222, 0);
    chk("t3_count", b.count, 0);
    chk("t3_credit", b.req_valid, 1);
    // drain then hold
    fire(3);
    b.hold_req = 1;
    cyc();
    chk("t4_drain_req", b.req_valid, 0);
    rsp(32'h1c00_0100, 64'h3333, 1);
    rsp(32'h1c00_0108, 64'h4444, 1);
    chk("t4_not_yet", b.hold_ack, 0);
    rsp(32'h1c00_0110, 64'h5555, 1);
    chk("t4_hold_ack", b.hold_ack, 1);
    b.out_ready = 1;
    repeat (3) cyc();
    chk("t4_hold_drained", b.count, 0);
    b.out_ready = 0; b.hold_req = 0;
    cyc();
    chk("t4_release", b.hold_ack, 0);
    // full queue, then steady push/pop across pointer wrap
    fire(4);
    for (int k = 0; k < 4; k++) rsp(32'h1c00_0200 + 32 * k, {32'hb000_0000 + k, 32'ha000_0000 + k}, 1);
    chk("t5_full", b.count, 4);
    b.out_ready = 1;
    cyc();
    fire(1);
    for (int k = 0; k < 8; k++) begin
      b.req_fire = 1;
      rsp(32'h1c00_0300 + 32 * k + 4 * (k % 2), {32'hd000_0000 + k, 32'hc000_0000 + k}, 1);
    end
    chk("t5_steady", b.count, 2);
    b.out_ready = 0;
    rsp(32'h1c00_0400, 64'h6666, 1);
    chk("t5_refill", b.count, 3);
    // reset mid-burst
    rst = 1;
    cyc();
    chk("t6_rst_valid", b.out_valid, 0);
    chk("t6_rst_count", b.count, 0);
    chk("t6_rst_pc", b.out_pc, 0);
    chk("t6_rst_epoch", b.req_epoch, 0);
    rst = 0;
    cyc();
    fire(1);
    b.out_ready = 1;
    set_rsp(32'h1c00_0504, {32'hbbbb0006, 32'haaaa0006}, 0);
    #1;
    chk("t6_same_cycle", b.out_valid, BYP);
    cyc();
    chk("t6_next_cycle", b.out_valid, !BYP);
    chk("t6_count", b.count, !BYP);
    b.out_ready = 0;
    repeat (2) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
